pmem_line_adapter: RTL and testbench
====================================

Name: pmem_line_adapter

Overview:
- Memory-side responder for the cache's physical-memory port. Accepts whole-line requests via pmem_read/pmem_write, holds until pmem_resp.
- Services each line as 8 sequential 16-bit word transactions on a narrow word bus to main memory.
- Assembles read lines and serialises write lines. Returns a one-cycle pmem_resp when the line completes.
- Sits between cache datapath/control and the word-wide memory model.

Parameters:
- WORD_W, 16, width of one word-bus beat in bits.
- BEATS, 8, beats per cache line; the line width is WORD_W*BEATS = 128.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pmem_address  in  16  line address from the cache; bits [3:0] are ignored except under the optional feature.
- pmem_read  in  1  line read request, held until pmem_resp.
- pmem_write  in  1  line write request, held until pmem_resp.
- pmem_wdata  in  128  line to write; word k occupies bits [16k+15:16k].
- pmem_rdata  out  128  assembled read line, valid in the pmem_resp cycle.
- pmem_resp  out  1  one-cycle completion pulse.
- word_address  out  16  word address = {pmem_address[15:4], beat, 1'b0}.
- word_read  out  1  beat read strobe, held until word_resp.
- word_write  out  1  beat write strobe, held until word_resp.
- word_wdata  out  16  beat write data.
- word_rdata  in  16  beat read data, valid when word_resp=1.
- word_resp  in  1  beat completion from memory.

Behaviour:
- Reset: reset=1 at a rising edge puts the FSM in S_IDLE and clears beat counter, line buffer and pmem_rdata. While in reset, all outputs are 0.
- Reset mid-operation: abandons the line with no pmem_resp. Word strobes drop in the cycle after the reset edge.
- States:
  - S_IDLE: if pmem_write=1, latch address tag, pmem_wdata and start beat, then go to S_WRITE. Else if pmem_read=1, latch address and start beat, then go to S_READ. Write wins if both are asserted.
  - S_READ: word_read=1 with word_address for the current beat. On word_resp, store word_rdata into line slot [beat] and advance the beat.
    - After the 8th beat, go to S_RESP.
  - S_WRITE: word_write=1 with word_wdata = latched slot [beat]. On word_resp, advance the beat.
    - After the 8th beat, go to S_RESP.
  - S_RESP: pmem_resp=1 for exactly one cycle. pmem_rdata = assembled line (reads); its value is unspecified after a write line. Then return to S_IDLE.
- Handshake rules:
  - Request inputs are sampled only in S_IDLE. Changes during S_READ/S_WRITE are ignored, since the latched copy is used.
  - The initiator drops its request in the cycle after pmem_resp. The cycle in S_IDLE following S_RESP therefore sees the request low, and no duplicate transaction occurs.
  - Word strobes are asserted continuously from state entry until word_resp. The next beat's strobe is asserted in the cycle after word_resp; there is no idle gap.
  - word_resp outside S_READ/S_WRITE is ignored.
- Beat counter: 3-bit and wraps modulo 8. Completion is counted by a separate 3-bit done counter reaching 7 on a word_resp.
- Latency: for memory latency L cycles per beat (word_resp in the L-th strobe cycle), pmem_resp arrives 8L+2 cycles after the request is first seen in S_IDLE.
- pmem_rdata holds the last assembled line until the next read completes or reset.

Optional Feature:
- Macro PMEM_LINE_ADAPTER_CRITICAL_WORD_FIRST_EN.
- Defined: the start beat is pmem_address[3:1]. Beats proceed start, start+1, ... wrapping mod 8, with 8 beats total. Each word still lands in slot [beat].
- Undefined: the start beat is always 0 and pmem_address[3:0] is fully ignored.
- Final pmem_rdata is identical in both builds.

Decomposition:
- Add to lc3b_types: lc3b_line (logic [127:0]) and lc3b_beat (logic [2:0]). lc3b_word already exists.
- One sub-module is natural: line_buffer. It is a 128-bit register with a 3-bit slot select, per-slot load, whole-line load and slot read mux, used for both the read-assembly and write-serialise paths.

Test Plan:
- Read, L=1: memory word at addr A = A^16'h5A5A. pmem_read @0x1230 → 8 reads at 0x1230,0x1232..0x123E. pmem_rdata slot k = (0x1230+2k)^0x5A5A. pmem_resp one cycle at 8*1+2=10 cycles.
- Write, L=3: pmem_write @0x4000, pmem_wdata = 128'h0007_0006_0005_0004_0003_0002_0001_0000 → 8 writes, word k = k at 0x4000+2k. pmem_resp at 26 cycles. A subsequent read returns the same line.
- Simultaneous pmem_read=pmem_write=1 @0x0100 → only word_write strobes are issued, and only one pmem_resp.
- Reset asserted after beat 4 of a read → strobes low in the next cycle, no pmem_resp, and the FSM idle. A new read then completes normally from beat 0.
- Request held one extra cycle after pmem_resp → no second transaction. pmem_rdata is stable until the next read.
- With CRITICAL_WORD_FIRST_EN, read @0x123A → beat addresses 0x123A,0x123C,0x123E,0x1230..0x1238, and the pmem_rdata contents are identical to the first scenario.

Source files
------------

// File: rtl/pmem_line_adapter_pkg.sv
// Shared types for the line adapter: word/line/beat containers and the FSM state encoding.
package pmem_line_adapter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;
  typedef logic [2:0]   lc3b_beat;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_e;

endpackage

// File: rtl/pmem_line_adapter_line_buffer.sv
// Line-wide register with per-slot load, whole-line load and slot read mux.
// Used both to assemble read lines and to serialise write lines.
module pmem_line_adapter_line_buffer #(
  parameter int WORD_W = 16,
  parameter int BEATS  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(BEATS)-1:0]    i_sel,
  input  logic                        i_slot_load,
  input  logic [WORD_W-1:0]           i_slot_data,
  input  logic                        i_line_load,
  input  logic [WORD_W*BEATS-1:0]     i_line_data,
  output logic [WORD_W-1:0]           o_slot_data,
  output logic [WORD_W*BEATS-1:0]     o_line,
  output logic [WORD_W*BEATS-1:0]     o_line_next
);

  localparam int SEL_W = $clog2(BEATS);

  logic [WORD_W*BEATS-1:0] r_line;
  logic [WORD_W*BEATS-1:0] w_line_next;

  // Whole-line load has priority; it is only used when a write line is accepted.
  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_slot
      assign w_line_next[gi*WORD_W +: WORD_W] =
        i_line_load ? i_line_data[gi*WORD_W +: WORD_W] :
        (i_slot_load && (i_sel == SEL_W'(gi))) ? i_slot_data :
        r_line[gi*WORD_W +: WORD_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_line <= '0;
    end else begin
      r_line <= w_line_next;
    end
  end

  assign o_slot_data = r_line[i_sel*WORD_W +: WORD_W];
  assign o_line      = r_line;
  assign o_line_next = w_line_next;

endmodule

// File: rtl/pmem_line_adapter.sv
// Cache-line to word-bus adapter: splits each line request into BEATS word transactions.
// Optional macro PMEM_LINE_ADAPTER_CRITICAL_WORD_FIRST_EN starts at the requested word.
module pmem_line_adapter
  import pmem_line_adapter_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int BEATS  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              pmem_address,
  input  logic                     pmem_read,
  input  logic                     pmem_write,
  input  logic [WORD_W*BEATS-1:0]  pmem_wdata,
  output logic [WORD_W*BEATS-1:0]  pmem_rdata,
  output logic                     pmem_resp,
  output logic [15:0]              word_address,
  output logic                     word_read,
  output logic                     word_write,
  output logic [WORD_W-1:0]        word_wdata,
  input  logic [WORD_W-1:0]        word_rdata,
  input  logic                     word_resp
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int TAG_LO = BEAT_W + 1;

  state_e                    r_state;
  state_e                    w_state_next;
  logic [BEAT_W-1:0]         r_beat;
  logic [BEAT_W-1:0]         r_done;
  logic [15:TAG_LO]          r_tag;
  logic [WORD_W*BEATS-1:0]   r_rdata;

  logic                      w_accept;
  logic                      w_accept_write;
  logic                      w_beat_ack;
  logic                      w_last_beat;
  logic [BEAT_W-1:0]         w_start_beat;
  logic [WORD_W-1:0]         w_slot_data;
  logic [WORD_W*BEATS-1:0]   w_line;
  logic [WORD_W*BEATS-1:0]   w_line_next;
  logic                      w_unused_addr;

`ifdef PMEM_LINE_ADAPTER_CRITICAL_WORD_FIRST_EN
  assign w_start_beat  = pmem_address[BEAT_W:1];
  assign w_unused_addr = pmem_address[0];
`else
  assign w_start_beat  = '0;
  assign w_unused_addr = ^pmem_address[BEAT_W:0];
`endif

  // Beat progress is judged by the done counter so a non-zero start beat still yields BEATS words.
  assign w_beat_ack  = word_resp && ((r_state == S_READ) || (r_state == S_WRITE));
  assign w_last_beat = w_beat_ack && (r_done == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_accept       = 1'b0;
    w_accept_write = 1'b0;
    word_read      = 1'b0;
    word_write     = 1'b0;
    pmem_resp      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (pmem_write) begin
          w_accept       = 1'b1;
          w_accept_write = 1'b1;
          w_state_next   = S_WRITE;
        end else if (pmem_read) begin
          w_accept       = 1'b1;
          w_state_next   = S_READ;
        end
      end
      S_READ: begin
        word_read = 1'b1;
        if (w_last_beat) w_state_next = S_RESP;
      end
      S_WRITE: begin
        word_write = 1'b1;
        if (w_last_beat) w_state_next = S_RESP;
      end
      S_RESP: begin
        pmem_resp    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat  <= '0;
      r_done  <= '0;
      r_tag   <= '0;
      r_rdata <= '0;
    end else if (w_accept) begin
      r_tag  <= pmem_address[15:TAG_LO];
      r_beat <= w_start_beat;
      r_done <= '0;
    end else if (w_beat_ack) begin
      r_beat <= r_beat + 1'b1;
      r_done <= r_done + 1'b1;
      // Capture the merged line so the final word is visible in the response cycle.
      if ((r_state == S_READ) && (r_done == '1)) r_rdata <= w_line_next;
    end
  end

  pmem_line_adapter_line_buffer #(
    .WORD_W (WORD_W),
    .BEATS  (BEATS)
  ) u_line_buffer (
    .clk         (clk),
    .reset       (reset),
    .i_sel       (r_beat),
    .i_slot_load (w_beat_ack && (r_state == S_READ)),
    .i_slot_data (word_rdata),
    .i_line_load (w_accept_write),
    .i_line_data (pmem_wdata),
    .o_slot_data (w_slot_data),
    .o_line      (w_line),
    .o_line_next (w_line_next)
  );

  logic w_unused_line;
  assign w_unused_line = ^w_line;

  assign pmem_rdata   = r_rdata;
  assign word_address = (word_read || word_write) ? {r_tag, r_beat, 1'b0} : 16'h0000;
  assign word_wdata   = word_write ? w_slot_data : '0;

endmodule

// File: tb/tb_pmem_line_adapter.sv
// Randomised scoreboard bench for pmem_line_adapter with a word-memory responder.
module tb_pmem_line_adapter;

  logic         clk;
  logic         reset;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  word_address;
  logic         word_read;
  logic         word_write;
  logic [15:0]  word_wdata;
  logic [15:0]  word_rdata;
  logic         word_resp;

  pmem_line_adapter dut (
    .clk          (clk),
    .reset        (reset),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .word_address (word_address),
    .word_read    (word_read),
    .word_write   (word_write),
    .word_wdata   (word_wdata),
    .word_rdata   (word_rdata),
    .word_resp    (word_resp)
  );

  typedef struct {
    logic [15:0] addr;
    bit          is_write;
    logic [15:0] wdata;
  } beat_t;

  typedef struct {
    bit           is_write;
    logic [127:0] line;
    int           req_cyc;
    int           lat;
  } resp_t;

  beat_t beat_q[$];
  resp_t resp_q[$];

  logic [15:0] ref_mem  [logic [15:0]];
  logic [15:0] phys_mem [logic [15:0]];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int mem_lat = 1;
  int beats_seen = 0;
  logic [127:0] last_read_line;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'h5A5A);
  endfunction

  // Word-memory responder: answers in the L-th cycle of each strobe and checks each beat.
  initial begin
    int cnt;
    beat_t e;
    cnt = 0;
    word_resp = 1'b0;
    word_rdata = 16'h0;
    forever begin
      @(negedge clk);
      word_resp = 1'b0;
      if (reset) begin
        cnt = 0;
      end else if (word_read || word_write) begin
        cnt++;
        if (cnt >= mem_lat) begin
          cnt = 0;
          beats_seen++;
          if (beat_q.size() == 0) begin
            chk("unexpected_beat", {word_read, word_write, word_address}, 128'h0);
          end else begin
            e = beat_q.pop_front();
            chk("beat_addr", word_address, e.addr);
            chk("beat_kind", {word_read, word_write}, e.is_write ? 2'b01 : 2'b10);
            if (e.is_write) chk("beat_wdata", word_wdata, e.wdata);
          end
          if (word_write) begin
            phys_mem[word_address] = word_wdata;
          end else begin
            word_rdata = phys_mem.exists(word_address) ? phys_mem[word_address]
                                                       : (word_address ^ 16'h5A5A);
          end
          word_resp = 1'b1;
        end
      end
    end
  end

  // Response monitor: every pmem_resp must match the oldest outstanding line.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (!reset && pmem_resp) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_resp", {127'h0, pmem_resp}, 128'h0);
        end else begin
          r = resp_q.pop_front();
          chk("latency", 128'(cyc - r.req_cyc + 1), 128'(8 * r.lat + 2));
          if (!r.is_write) chk("rdata", pmem_rdata, r.line);
        end
      end
    end
  end

  task automatic issue(input bit rd, input bit wr, input logic [15:0] addr,
                       input logic [127:0] wd, input int lat);
    resp_t       r;
    beat_t       b;
    logic [2:0]  start;
    logic [2:0]  s;
    logic [15:0] a;
`ifdef PMEM_LINE_ADAPTER_CRITICAL_WORD_FIRST_EN
    start = addr[3:1];
`else
    start = 3'd0;
`endif
    r.is_write = wr;
    r.line     = '0;
    for (int i = 0; i < 8; i++) begin
      s = start + 3'(i);
      a = {addr[15:4], s, 1'b0};
      b.addr     = a;
      b.is_write = wr;
      b.wdata    = wd[s*16 +: 16];
      beat_q.push_back(b);
      if (wr) ref_mem[a] = wd[s*16 +: 16];
      else    r.line[s*16 +: 16] = ref_rd(a);
    end
    r.req_cyc = cyc;
    r.lat     = lat;
    resp_q.push_back(r);
    if (!wr) last_read_line = r.line;
    mem_lat      = lat;
    beats_seen   = 0;
    pmem_address = addr;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_wdata   = wd;
  endtask

  task automatic wait_done();
    bit got;
    got = 0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(posedge clk); #1;
      if (pmem_resp) got = 1;
      else if (n > 0) begin
        // Request inputs are scrambled mid-line; the adapter must use its latched copy.
        pmem_address = 16'($urandom);
        pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    if (!got) chk("resp_timeout", 128'h0, 128'h1);
    @(posedge clk); #1;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    chk("beats_left", 128'(beat_q.size()), 128'h0);
  endtask

  task automatic line_op(input bit rd, input bit wr, input logic [15:0] addr,
                         input logic [127:0] wd, input int lat);
    issue(rd, wr, addr, wd, lat);
    wait_done();
  endtask

  initial begin
    logic [127:0] wd;
    logic [15:0]  addr;
    int           kind;
    bit           ok;

    reset = 1'b1;
    pmem_address = 16'h0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {pmem_resp, word_read, word_write, word_address, word_wdata, pmem_rdata[63:0]},
        128'h0);
    chk("reset_rdata", pmem_rdata, 128'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Read, L=1
    line_op(1'b1, 1'b0, 16'h1230, '0, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rdata_hold", pmem_rdata, last_read_line);
    end

    // Write, L=3, then read back
    line_op(1'b0, 1'b1, 16'h4000, 128'h0007_0006_0005_0004_0003_0002_0001_0000, 3);
    line_op(1'b1, 1'b0, 16'h4000, '0, 2);
    chk("write_readback", last_read_line, 128'h0007_0006_0005_0004_0003_0002_0001_0000);

    // Simultaneous read and write: write wins
    line_op(1'b1, 1'b1, 16'h0100, 128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444, 1);
    repeat (3) @(posedge clk);
    #1;

    // Reset after four beats of a read
    issue(1'b1, 1'b0, 16'h2220, '0, 2);
    ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(posedge clk); #1;
      if (beats_seen >= 4) ok = 1;
    end
    if (!ok) chk("beat4_timeout", 128'h0, 128'h1);
    reset = 1'b1;
    pmem_read = 1'b0;
    beat_q.delete();
    resp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("reset_midop_strobes", {word_read, word_write, pmem_resp}, 3'b000);
    chk("reset_midop_rdata", pmem_rdata, 128'h0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("reset_idle", {word_read, word_write, pmem_resp}, 3'b000);
    end
    line_op(1'b1, 1'b0, 16'h2220, '0, 1);

    // Critical-word address (start beat differs only in that build)
    line_op(1'b1, 1'b0, 16'h123A, '0, 1);
    chk("cwf_line", last_read_line, {16'h123E ^ 16'h5A5A, 16'h123C ^ 16'h5A5A,
        16'h123A ^ 16'h5A5A, 16'h1238 ^ 16'h5A5A, 16'h1236 ^ 16'h5A5A,
        16'h1234 ^ 16'h5A5A, 16'h1232 ^ 16'h5A5A, 16'h1230 ^ 16'h5A5A});

    // Randomised traffic over a few lines
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      addr = 16'h3000 | 16'($urandom_range(0, 3) << 4) | 16'($urandom_range(0, 15));
      wd   = {$urandom, $urandom, $urandom, $urandom};
      line_op(kind != 1, kind != 0, addr, wd, $urandom_range(1, 4));
      if (kind == 0) begin
        repeat (2) @(posedge clk);
        #1;
        chk("rand_rdata_hold", pmem_rdata, last_read_line);
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("resp_left", 128'(resp_q.size()), 128'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
